// File: rtl/sipo_pkg.sv
// Shared definitions for the sipo_deser deserialiser: bit-order constants,
// output buffer states and the bit-counter width helper.
package sipo_pkg;

  localparam bit ORDER_LSB = 1'b0;
  localparam bit ORDER_MSB = 1'b1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Counter covers 0..WIDTH-1; keep at least one bit so the port never collapses.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; word_done/word flag the word completed by
// the bit accepted this cycle, so the buffer can capture it on the same edge.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = ORDER_MSB,
  parameter int unsigned CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             clear,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    if (clear) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (d_valid) begin
      if (MSB_FIRST == ORDER_MSB) sh_d = {sh_q[WIDTH-2:0], d};
      else                        sh_d = {d, sh_q[WIDTH-1:1]};
      if (cnt_q == LAST) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // The completed word includes the bit being accepted, hence the next-state value.
  assign word    = sh_d;
  assign bit_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with a one-entry valid/ready output
// buffer and a sticky overrun flag for words dropped while the buffer is full.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = ORDER_MSB
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       d,
  input  logic                       d_valid,
  input  logic                       clear,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic                       busy,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                       overrun
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic             word_done;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt;

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             overrun_q, overrun_d;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CW       (CW)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .d_valid  (d_valid),
    .clear    (clear),
    .bit_cnt  (cnt),
    .word_done(word_done),
    .word     (word)
  );

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    overrun_d = overrun_q;
    if (clear) begin
      state_d   = BUF_EMPTY;
      q_d       = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (word_done) begin
            state_d = BUF_FULL;
            q_d     = word;
          end
        end
        BUF_FULL: begin
          if (word_done) begin
            // Consumer taking the old word frees the slot on the same edge.
            if (q_ready) q_d = word;
            else         overrun_d = 1'b1;
          end else if (q_ready) begin
            state_d = BUF_EMPTY;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUF_EMPTY;
      q_q       <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      overrun_q <= overrun_d;
    end
  end

  assign q       = q_q;
  assign q_valid = (state_q == BUF_FULL);
  assign overrun = overrun_q;
  assign bit_cnt = cnt;
  assign busy    = (cnt != '0);

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share stimulus and are
// compared against a bit-list reference model after every clock.
module tb_sipo_deser;

  localparam int W  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst, d, d_valid, clear, q_ready;

  logic [W-1:0]  q_m, q_l;
  logic          qv_m, qv_l, busy_m, busy_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit       bits_q[$];
  bit       m_valid, m_ovr;
  bit [W-1:0] m_qm, m_ql;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .clear(clear),
    .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .busy(busy_m),
    .bit_cnt(cnt_m), .overrun(ovr_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .clear(clear),
    .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .busy(busy_l),
    .bit_cnt(cnt_l), .overrun(ovr_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    m_valid = 0;
    m_ovr   = 0;
    m_qm    = '0;
    m_ql    = '0;
  endtask

  task automatic model_step(input bit bd, input bit bdv, input bit brdy, input bit bclr);
    bit done;
    bit [W-1:0] wm, wl;
    done = 0;
    wm = '0;
    wl = '0;
    if (bclr) begin
      model_reset();
      return;
    end
    if (bdv) begin
      bits_q.push_back(bd);
      if (bits_q.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits_q[i];
          wl[i]     = bits_q[i];
        end
        done = 1;
        bits_q.delete();
      end
    end
    if (!m_valid) begin
      if (done) begin
        m_valid = 1;
        m_qm = wm;
        m_ql = wl;
      end
    end else if (done) begin
      if (brdy) begin
        m_qm = wm;
        m_ql = wl;
      end else begin
        m_ovr = 1;
      end
    end else if (brdy) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " q_msb"},     32'(q_m),    32'(m_qm));
    check({tag, " q_lsb"},     32'(q_l),    32'(m_ql));
    check({tag, " q_valid"},   32'({qv_m, qv_l}),   {30'd0, m_valid, m_valid});
    check({tag, " overrun"},   32'({ovr_m, ovr_l}), {30'd0, m_ovr, m_ovr});
    check({tag, " bit_cnt_m"}, 32'(cnt_m),  32'(bits_q.size()));
    check({tag, " bit_cnt_l"}, 32'(cnt_l),  32'(bits_q.size()));
    check({tag, " busy"},      32'({busy_m, busy_l}),
          {30'd0, bits_q.size() != 0, bits_q.size() != 0});
  endtask

  task automatic step(input string tag, input bit bd, input bit bdv, input bit brdy, input bit bclr);
    @(negedge clk);
    d = bd;
    d_valid = bdv;
    q_ready = brdy;
    clear = bclr;
    @(posedge clk);
    model_step(bd, bdv, brdy, bclr);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit [3:0] s1, s2, s3;
    s1 = 4'b1011;
    s2 = 4'b0110;
    s3 = 4'b0110;
    rst = 1'b1; d = 0; d_valid = 0; clear = 0; q_ready = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1011 with no gaps, consumer stalled
    for (int i = 3; i >= 0; i--) step("stream", s1[i], 1, 0, 0);
    check("plan q_msb 1011", 32'(q_m), 32'hB);
    check("plan q_lsb 1101", 32'(q_l), 32'hD);

    // Same word with gaps after a flush
    step("flush", 0, 0, 0, 1);
    for (int i = 3; i >= 0; i--) begin
      step("gap_bit", s1[i], 1, 0, 0);
      step("gap_idle", 0, 0, 0, 0);
    end
    check("plan gap q_msb", 32'(q_m), 32'hB);

    // Second word while full and stalled -> overrun, q kept
    for (int i = 3; i >= 0; i--) step("overrun", s2[i], 1, 0, 0);
    check("plan overrun flag", 32'(ovr_m), 32'd1);
    check("plan overrun q kept", 32'(q_m), 32'hB);
    step("clear", 1, 1, 1, 1);

    // Back-to-back with consumer always ready
    for (int i = 3; i >= 0; i--) step("b2b_w1", s1[i], 1, 1, 0);
    for (int i = 3; i >= 0; i--) step("b2b_w2", s2[i], 1, 1, 0);
    check("plan b2b q_msb", 32'(q_m), 32'h6);
    step("b2b_drain", 0, 0, 1, 0);

    // Asynchronous reset mid-word, mid-cycle
    step("pre_rst", 1, 1, 0, 0);
    step("pre_rst", 1, 1, 0, 0);
    @(negedge clk);
    d_valid = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    for (int i = 3; i >= 0; i--) step("post_rst", s3[i], 1, 0, 0);
    check("plan post_rst q_msb", 32'(q_m), 32'h6);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step("random", 1'($urandom), ($urandom_range(3, 0) != 0),
           1'($urandom), ($urandom_range(39, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserialiser, the successor to the fixed 4-bit SIPO register. It shifts one qualified serial bit per clock into a WIDTH-bit word and selects MSB-first or LSB-first bit order. Each completed word goes to a one-entry output buffer with a valid/ready handshake, and the block flags any word dropped for lack of space. It sits between a serial front end and a word-wide consumer.

## Interface
Parameters:
- WIDTH, 4, word width in bits; legal range is WIDTH ≥ 2.
- MSB_FIRST, 1, bit order. 1: first received bit lands in q[WIDTH-1]. 0: first received bit lands in q[0].

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  1  serial data bit.
- d_valid  input  1  qualifies d; the bit is sampled only when d_valid=1.
- clear  input  1  synchronous flush of all state except the reset itself.
- q  output  WIDTH  buffered parallel word.
- q_valid  output  1  q holds an unconsumed word.
- q_ready  input  1  consumer accepts q this cycle when q_valid=1.
- busy  output  1  partial word in progress (bit_cnt≠0).
- bit_cnt  output  $clog2(WIDTH)  number of bits collected in the current word.
- overrun  output  1  sticky flag: a completed word was dropped.

## Operation
- Internal shift register sh[WIDTH-1:0] and counter bit_cnt, range 0..WIDTH-1.
- Shift on d_valid=1:
  - MSB_FIRST=1: sh ← {sh[WIDTH-2:0], d}.
  - MSB_FIRST=0: sh ← {d, sh[WIDTH-1:1]}.
- bit_cnt increments on each accepted bit. On the WIDTH-th bit it wraps to 0 and the word completes.
- The completed word is the shifted value including the last bit, not the pre-shift sh.
- Output buffer has two states, EMPTY (q_valid=0) and FULL (q_valid=1):
  - EMPTY + word completes → FULL, q ← word.
  - FULL + q_ready=1 with no completion → EMPTY. q keeps its last value.
  - FULL + q_ready=1 + completion in the same cycle → stays FULL, q ← new word. No bubble, no overrun.
  - FULL + q_ready=0 + completion → word dropped, q unchanged, overrun ← 1.
- overrun stays set until rst or clear.
- d_valid=0 cycles are gaps: sh and bit_cnt hold.
- clear=1 takes priority over d_valid and q_ready. Next cycle: sh=0, bit_cnt=0, q_valid=0, overrun=0, q=0.
- rst (asynchronous) forces the same all-zero state immediately, including mid-word. Partial bits are discarded.

## Timing
- Reset values: q=0, q_valid=0, busy=0, bit_cnt=0, overrun=0.
- Latency: q_valid rises on the same rising edge that samples the last bit of a word, so it is visible in the following cycle.
- Throughput: one bit per cycle sustained, and one word per WIDTH cycles with no gaps when q_ready is held high.
- Handshake: a transfer occurs on an edge where q_valid=1 and q_ready=1. q_valid never depends combinationally on q_ready.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package sipo_pkg:
  - bit-order localparams ORDER_LSB=0 and ORDER_MSB=1;
  - function for the counter width, $clog2(WIDTH).
- One sub-module, sipo_shift_core: the shift register plus bit counter with a word_done pulse.
- The top level adds the output buffer FSM, overrun logic and clear handling.

## Test plan
- WIDTH=4, MSB_FIRST=1, d=1,0,1,1 on consecutive cycles with d_valid=1 and q_ready=0 → q=4'b1011 and q_valid=1 from the cycle after the 4th bit. bit_cnt goes 1,2,3,0. busy=1 during bits 1–3.
- MSB_FIRST=0, same stream → q=4'b1101.
- Same stream with d_valid=0 inserted between every bit → identical q. bit_cnt holds during gaps.
- q_ready=0, send 1011 then 0110 → q stays 4'b1011, overrun=1 after the 8th bit. Then assert clear → q_valid=0, overrun=0.
- q_ready=1 permanently, back-to-back stream 1011 then 0110 → q=1011 for 4 cycles, then 0110. q_valid stays continuously 1 after the first word. overrun=0.
- After 2 bits of a word, pulse rst asynchronously mid-cycle → all outputs 0 immediately. The next 4 bits 0,1,1,0 yield q=4'b0110.
